// File: rtl/sha2_pkg.sv
// Shared types, constants and round functions for the SHA-256/224 block engine.
package sha2_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROUNDS = 2'd2,
    ST_FINAL  = 2'd3
  } state_e;

  // Working variables a..h (also used for the chaining value H0..H7, a = H0)
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Initial hash value for the selected variant, packed H0 first
  function automatic work_t iv_words(input logic is224);
    work_t r;
    if (is224) begin
      r = {IV224[0], IV224[1], IV224[2], IV224[3], IV224[4], IV224[5], IV224[6], IV224[7]};
    end else begin
      r = {IV256[0], IV256[1], IV256[2], IV256[3], IV256[4], IV256[5], IV256[6], IV256[7]};
    end
    return r;
  endfunction

  // Word-wise modulo-2^32 sum used for the end-of-block feed-forward
  function automatic work_t add_work(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: (a..h, K, W) -> (a'..h').
module sha2_round
  import sha2_pkg::*;
(
  input  work_t       st_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       st_o
);

  logic [31:0] t1;
  logic [31:0] t2;

  // Standard round: two temporaries, then rotate the working variables
  always_comb begin
    t1 = st_i.h + bsig1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
    t2 = bsig0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
    st_o = '{a: t1 + t2, b: st_i.a, c: st_i.b, d: st_i.c,
             e: st_i.d + t1, f: st_i.e, g: st_i.f, h: st_i.g};
  end

endmodule

// File: rtl/sha2_block_engine.sv
// SHA-256/224 block engine: loads 16 message words, runs 64 rounds at
// UNROLL rounds per clock, then folds the result into the chaining value.
module sha2_block_engine
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter bit EN_224 = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                init_i,
  input  logic                mode_i,
  input  logic                m_valid_i,
  output logic                m_ready_o,
  input  logic [31:0]         m_data_i,
  output logic [5:0]          k_addr_o,
  input  logic [32*UNROLL-1:0] k_data_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [255:0]        digest_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha2_block_engine: UNROLL must be 1, 2 or 4");
  end

  localparam logic [5:0] ROUND_STEP = 6'(UNROLL);
  localparam logic [5:0] LAST_ROUND = 6'(64 - UNROLL);

  state_e             state_q;
  logic [3:0]         wcnt_q;
  logic [5:0]         rcnt_q;
  work_t              h_q;
  work_t              wv_q;
  logic [15:0][31:0]  w_q;        // message window, w0 at index 0
  logic               mode224_q;
  logic               busy_q;
  logic               done_q;
  logic               m_ready_q;

  work_t              wv_d;
  logic [15:0][31:0]  w_d;
  logic               sel224;

  // MODE only matters when the 224 variant is built in
  assign sel224 = (EN_224 != 1'b0) && mode_i;

  // Chain of UNROLL rounds; each stage also slides the schedule window by one
  // word so stage i always sees its W at the window head.
  genvar gi;
  for (gi = 0; gi < UNROLL; gi++) begin : g_round
    work_t             st_in;
    work_t             st_out;
    logic [15:0][31:0] win_in;
    logic [15:0][31:0] win_out;
    logic [31:0]       w_new;

    if (gi == 0) begin : g_head
      assign st_in  = wv_q;
      assign win_in = w_q;
    end else begin : g_link
      assign st_in  = g_round[gi-1].st_out;
      assign win_in = g_round[gi-1].win_out;
    end

    // Uniform schedule rule for every round; words produced late are simply unused
    assign w_new   = ssig1(win_in[14]) + win_in[9] + ssig0(win_in[1]) + win_in[0];
    assign win_out = {w_new, win_in[15:1]};

    sha2_round u_round (
      .st_i (st_in),
      .k_i  (k_data_i[32*gi +: 32]),
      .w_i  (win_in[0]),
      .st_o (st_out)
    );
  end

  assign wv_d = g_round[UNROLL-1].st_out;
  assign w_d  = g_round[UNROLL-1].win_out;

  // Control FSM plus all datapath registers; outputs come straight from flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      h_q       <= iv_words(1'b0);
      wv_q      <= '0;
      w_q       <= '0;
      mode224_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            m_ready_q <= 1'b1;
            wcnt_q    <= '0;
            state_q   <= ST_LOAD;
            if (init_i) begin
              h_q       <= iv_words(sel224);
              wv_q      <= iv_words(sel224);
              mode224_q <= sel224;
            end else begin
              wv_q <= h_q;
            end
          end
        end
        ST_LOAD: begin
          if (m_valid_i && m_ready_q) begin
            w_q    <= {m_data_i, w_q[15:1]};
            wcnt_q <= wcnt_q + 4'd1;
            if (wcnt_q == 4'd15) begin
              m_ready_q <= 1'b0;
              rcnt_q    <= '0;
              state_q   <= ST_ROUNDS;
            end
          end
        end
        ST_ROUNDS: begin
          wv_q   <= wv_d;
          w_q    <= w_d;
          rcnt_q <= rcnt_q + ROUND_STEP;
          if (rcnt_q == LAST_ROUND) begin
            state_q <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          h_q     <= add_work(h_q, wv_q);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          rcnt_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_ready_o = m_ready_q;
  assign k_addr_o  = rcnt_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  // SHA-224 hides H7 on the output only; the register keeps it for chaining
  assign digest_o  = {h_q[255:32], (mode224_q ? 32'h0 : h_q.h)};

endmodule

// File: tb/tb_sha2_block_engine.sv
// Directed scoreboard bench: three engines (UNROLL 1, 2, 4) share one stimulus stream.
module tb_sha2_block_engine;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256_D = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC256  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ABC224  = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] TWO256  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  typedef struct {
    bit           chk;
    logic [255:0] dig;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         init;
  logic         mode;
  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_ready [3];
  logic         busy    [3];
  logic         done    [3];
  logic [5:0]   k_addr  [3];
  logic [255:0] digest  [3];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  hs_cnt   [3];
  int  last_hs  [3];
  int  done_cnt [3];
  sb_t sbq [3][$];

  logic [31:0] abc_blk [16];
  logic [31:0] two_b1  [16];
  logic [31:0] two_b2  [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi, gj;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    logic [32*(1<<gi)-1:0] kd;
    for (gj = 0; gj < (1 << gi); gj++) begin : g_k
      assign kd[32*gj +: 32] = K_TAB[k_addr[gi] + 6'(gj)];
    end
    sha2_block_engine #(.UNROLL(1 << gi), .EN_224(1'b1)) u_dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .init_i    (init),
      .mode_i    (mode),
      .m_valid_i (m_valid),
      .m_ready_o (m_ready[gi]),
      .m_data_i  (m_data),
      .k_addr_o  (k_addr[gi]),
      .k_data_i  (kd),
      .busy_o    (busy[gi]),
      .done_o    (done[gi]),
      .digest_o  (digest[gi])
    );
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-engine monitor: handshake counting, K_ADDR / M_READY during rounds,
  // DONE latency and scoreboard pop on completion
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      int n;
      int j;
      n = 64 >> d;
      if (!rst_n) begin
        hs_cnt[d]  = 0;
        last_hs[d] = -1;
      end else begin
        if (m_valid && m_ready[d]) begin
          hs_cnt[d]++;
          if (hs_cnt[d] == 16) begin
            hs_cnt[d]  = 0;
            last_hs[d] = cyc + 1;
          end
        end
        if (last_hs[d] >= 0 && cyc >= last_hs[d]) begin
          j = cyc - last_hs[d];
          if (j < n) check($sformatf("k_addr_u%0d", 1 << d), 256'(k_addr[d]), 256'(j << d));
          if (j <= n) check($sformatf("m_ready_rounds_u%0d", 1 << d), 256'(m_ready[d]), 256'(0));
          if (done[d]) begin
            done_cnt[d]++;
            check($sformatf("done_latency_u%0d", 1 << d), 256'(j), 256'(n + 1));
            last_hs[d] = -1;
            if (sbq[d].size() == 0) begin
              check($sformatf("sb_empty_u%0d", 1 << d), 256'(0), 256'(1));
            end else begin
              sb_t e;
              e = sbq[d].pop_front();
              $display("u%0d block done at cycle %0d digest=%h", 1 << d, cyc, digest[d]);
              if (e.chk) check($sformatf("digest_u%0d", 1 << d), digest[d], e.dig);
            end
          end else if (j > n + 1) begin
            check($sformatf("done_timeout_u%0d", 1 << d), 256'(j), 256'(n + 1));
            last_hs[d] = -1;
          end
        end else if (done[d]) begin
          done_cnt[d]++;
          check($sformatf("done_unexpected_u%0d", 1 << d), 256'(1), 256'(0));
        end
      end
    end
  end

  task automatic push_exp(input bit chk, input logic [255:0] dig);
    sb_t e;
    e.chk = chk;
    e.dig = dig;
    for (int d = 0; d < 3; d++) sbq[d].push_back(e);
  endtask

  task automatic begin_block(input bit ini, input bit md);
    start = 1'b1;
    init  = ini;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check($sformatf("busy_after_start_u%0d", 1 << d), 256'(busy[d]), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [31:0] blk [16], input bit gappy);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (n < 16 && guard < 100) begin
      m_data  = blk[n];
      m_valid = gappy ? (guard % 2 == 0) : 1'b1;
      @(negedge clk);
      if (m_valid && m_ready[0]) n++;
      @(posedge clk); #1;
      guard++;
    end
    m_valid = 1'b0;
    check("load_words", 256'(n), 256'(16));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      if (!busy[0] && !busy[1] && !busy[2]) break;
      guard++;
    end
    check("busy_clear", 256'({busy[0], busy[1], busy[2]}), 256'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_done_delta(input int base [3], input int delta);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("done_count_u%0d", 1 << d), 256'(done_cnt[d] - base[d]), 256'(delta));
      check($sformatf("sb_drained_u%0d", 1 << d), 256'(sbq[d].size()), 256'(0));
    end
  endtask

  initial begin
    int base [3];
    for (int i = 0; i < 16; i++) begin
      abc_blk[i] = 32'h0;
      two_b2[i]  = 32'h0;
    end
    abc_blk[0]  = 32'h61626380;
    abc_blk[15] = 32'h00000018;
    two_b1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b2[15] = 32'h000001c0;
    for (int d = 0; d < 3; d++) begin
      hs_cnt[d] = 0; last_hs[d] = -1; done_cnt[d] = 0;
    end

    rst_n = 1'b0; start = 1'b0; init = 1'b0; mode = 1'b0; m_valid = 1'b0; m_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_digest_u%0d", 1 << d), digest[d], IV256_D);
      check($sformatf("rst_busy_u%0d", 1 << d), 256'(busy[d]), 256'(0));
      check($sformatf("rst_done_u%0d", 1 << d), 256'(done[d]), 256'(0));
      check($sformatf("rst_ready_u%0d", 1 << d), 256'(m_ready[d]), 256'(0));
      check($sformatf("rst_kaddr_u%0d", 1 << d), 256'(k_addr[d]), 256'(0));
    end
    @(posedge clk); #1;

    // SHA-256 "abc"
    base = done_cnt;
    push_exp(1'b1, ABC256);
    begin_block(1'b1, 1'b0);
    send_block(abc_blk, 1'b0);
    wait_idle();
    check_done_delta(base, 1);

    // SHA-224 "abc"
    base = done_cnt;
    push_exp(1'b1, ABC224);
    begin_block(1'b1, 1'b1);
    send_block(abc_blk, 1'b0);
    wait_idle();
    check_done_delta(base, 1);

    // Two-block message, second block chains from the first
    base = done_cnt;
    push_exp(1'b0, 256'h0);
    begin_block(1'b1, 1'b0);
    send_block(two_b1, 1'b0);
    wait_idle();
    push_exp(1'b1, TWO256);
    begin_block(1'b0, 1'b0);
    send_block(two_b2, 1'b0);
    wait_idle();
    check_done_delta(base, 2);

    // Gappy M_VALID and a START (asking for 224) while rounds run
    base = done_cnt;
    push_exp(1'b1, ABC256);
    begin_block(1'b1, 1'b0);
    send_block(abc_blk, 1'b1);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; init = 1'b1; mode = 1'b1;
    @(posedge clk); #1 start = 1'b0; init = 1'b0; mode = 1'b0;
    wait_idle();
    check_done_delta(base, 1);

    // Reset at round 30 of the UNROLL=1 engine
    base = done_cnt;
    push_exp(1'b1, ABC256);
    begin_block(1'b1, 1'b0);
    send_block(abc_blk, 1'b0);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("midrst_busy_u%0d", 1 << d), 256'(busy[d]), 256'(0));
      check($sformatf("midrst_done_u%0d", 1 << d), 256'(done[d]), 256'(0));
      check($sformatf("midrst_digest_u%0d", 1 << d), digest[d], IV256_D);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_pending_u1", 256'(sbq[0].size()), 256'(1));
    check("midrst_pending_u2", 256'(sbq[1].size()), 256'(1));
    check("midrst_pending_u4", 256'(sbq[2].size()), 256'(0));
    check("midrst_nodone_u1", 256'(done_cnt[0] - base[0]), 256'(0));
    check("midrst_nodone_u2", 256'(done_cnt[1] - base[1]), 256'(0));
    for (int d = 0; d < 3; d++) sbq[d].delete();

    // Chain from the reset IV without INIT
    base = done_cnt;
    push_exp(1'b1, ABC256);
    begin_block(1'b0, 1'b0);
    @(negedge clk);
    check("noinit_digest_kept", digest[0], IV256_D);
    @(posedge clk); #1;
    send_block(abc_blk, 1'b0);
    wait_idle();
    check_done_delta(base, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
